// File: rtl/mem_access_arbiter_pkg.sv
// mem_arb_pkg: shared constants and FSM state encoding for mem_access_arbiter.
// Rev 1.0
`default_nettype none

package mem_arb_pkg;

  localparam int REQ_N      = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;
  localparam int CNT_W      = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/mem_access_arbiter_rr.sv
// rr_arbiter2: combinational 2-way winner select (round-robin, or fixed priority
// when MEM_ARB_FIXED_PRIO_EN is defined). Rev 1.0
`default_nettype none

module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic             last,
  output logic [REQ_N-1:0] grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant = '0;
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
  end
`else
  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: two-requester arbiter and setup/strobe/hold sequencer for a
// 4 x 8-bit byte memory. Optional macro: MEM_ARB_FIXED_PRIO_EN. Rev 1.0
`default_nettype none

module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REQ_N-1:0]      req,
  input  logic [REQ_N-1:0]      we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [REQ_N-1:0]      gnt,
  output logic [REQ_N-1:0]      done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data,
  output logic                  mem_store,
  input  logic [DATA_W-1:0]     mem_q
);

  state_t           state;
  logic             last;
  logic             cur;
  logic             cur_we;
  logic [CNT_W-1:0] cnt;
  logic [REQ_N-1:0] grant;

  rr_arbiter2 u_arb (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  // mem_addr/mem_data double as the latched access values, so they stay put in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      cur       <= 1'b0;
      cur_we    <= 1'b0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      mem_store <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      rdata     <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        S_IDLE: begin
          if (|grant) begin
            cur      <= grant[1];
            cur_we   <= grant[1] ? we[1] : we[0];
            mem_addr <= grant[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            mem_data <= grant[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            gnt      <= grant;
            busy     <= 1'b1;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cur_we) begin
            mem_store <= 1'b1;
            cnt       <= CNT_W'(STROBE_CYCLES - 1);
            state     <= S_STROBE;
          end else begin
            state <= S_SAMPLE;
          end
        end
        S_STROBE: begin
          if (cnt == '0) begin
            mem_store <= 1'b0;
            state     <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: state <= S_DONE;
        S_SAMPLE: begin
          rdata <= mem_q;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= cur ? 2'b10 : 2'b01;
          last  <= cur;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          mem_store <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
